// File: rtl/aes_arb_pkg.sv
// ----------------------------------------------------------------------------
// aes_arb_pkg
// Shared definitions for the AES request arbiter:
//   - AES_BLOCK_W          : width of one AES block / key (128)
//   - AES_ARB_TIMEOUT_DEF  : default RUN watchdog limit in cycles
//   - arb_state_e          : FSM encoding IDLE=0, LOAD=1, RUN=2, RESP=3
//   - cnt_width()          : bits needed to count 0..n-1 (minimum 1)
// ----------------------------------------------------------------------------
package aes_arb_pkg;

   localparam int AES_BLOCK_W         = 128;
   localparam int AES_ARB_TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } arb_state_e;

   // Width of a counter that must hold the values 0..n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// ----------------------------------------------------------------------------
// aes_rr_arbiter
// Purely combinational round-robin pick. The search starts at i_ptr+1 and
// wraps modulo NUM_REQ, so the last winner has the lowest priority.
// Ports:
//   i_req  [NUM_REQ]  request vector
//   i_ptr  [ID_W]     index of the previous winner (0..NUM_REQ-1)
//   o_gnt  [NUM_REQ]  one-hot grant (all zero when nothing requests)
//   o_idx  [ID_W]     encoded index of the granted requester
//   o_any             at least one request present
// ----------------------------------------------------------------------------
module aes_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   // Two passes instead of a rotate: first the positions strictly above the
   // pointer, then (only if none hit) the positions at or below it. Each pass
   // walks downwards so the lowest matching position is the last one written.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int p = NUM_REQ-1; p >= 0; p--) begin
         if (i_req[p] && (ID_W'(p) > i_ptr)) begin
            o_gnt    = '0;
            o_gnt[p] = 1'b1;
            o_idx    = ID_W'(p);
            o_any    = 1'b1;
         end
      end
      if (!o_any) begin
         for (int p = NUM_REQ-1; p >= 0; p--) begin
            if (i_req[p] && (ID_W'(p) <= i_ptr)) begin
               o_gnt    = '0;
               o_gnt[p] = 1'b1;
               o_idx    = ID_W'(p);
               o_any    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/aes_request_arbiter.sv
// ----------------------------------------------------------------------------
// aes_request_arbiter
// Shares a single AES-128 encrypt core between NUM_REQ requesters. A
// round-robin winner is accepted in IDLE, its plaintext/key are latched onto
// the core inputs, the core is held in load for one cycle (LOAD), released
// (RUN) until it reports ready, and the ciphertext is returned with the
// requester index on a valid/ready response channel (RESP).
//
// Optional build macro: AES_ARB_TIMEOUT_EN
//   When defined, a RUN watchdog of TIMEOUT_CYCLES cycles ends a stuck
//   transaction with rsp_data=0, rsp_err=1. When undefined, RUN waits
//   indefinitely and rsp_err is tied to 0.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_data/req_key     requester i at [128*i +: 128]
//   rsp_valid/rsp_ready  response handshake
//   rsp_data/rsp_id/rsp_err  ciphertext, requester index, timeout flag
//   core_reset_n         low = core loads/holds, high = core runs
//   core_in/core_key     block and key presented to the core
//   core_out/core_ready  core result and completion flag
// ----------------------------------------------------------------------------
module aes_request_arbiter
   import aes_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = AES_ARB_TIMEOUT_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [AES_BLOCK_W*NUM_REQ-1:0] req_data,
   input  logic [AES_BLOCK_W*NUM_REQ-1:0] req_key,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [AES_BLOCK_W-1:0]         rsp_data,
   output logic [ID_W-1:0]                rsp_id,
   output logic                           rsp_err,
   output logic                           core_reset_n,
   output logic [AES_BLOCK_W-1:0]         core_in,
   output logic [AES_BLOCK_W-1:0]         core_key,
   input  logic [AES_BLOCK_W-1:0]         core_out,
   input  logic                           core_ready
);

   // Elaboration-time parameter sanity checks.
   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_chk_num_req
      $error("aes_request_arbiter: NUM_REQ must be in 2..16");
   end
   if (ID_W < 1 || (2**ID_W) < NUM_REQ) begin : g_chk_id_w
      $error("aes_request_arbiter: ID_W too narrow for NUM_REQ");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
      $error("aes_request_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   arb_state_e             r_state;
   arb_state_e             w_state_nxt;
   logic [ID_W-1:0]        r_ptr;
   logic [ID_W-1:0]        r_rsp_id;
   logic [AES_BLOCK_W-1:0] r_core_in;
   logic [AES_BLOCK_W-1:0] r_core_key;
   logic [AES_BLOCK_W-1:0] r_rsp_data;

   logic [NUM_REQ-1:0]     w_gnt;
   logic [ID_W-1:0]        w_gnt_idx;
   logic                   w_gnt_any;
   logic                   w_accept;
   logic                   w_core_done;
   logic                   w_timeout;
   logic [AES_BLOCK_W-1:0] w_sel_data;
   logic [AES_BLOCK_W-1:0] w_sel_key;

   // -------------------------------------------------------------------------
   // Arbitration and request selection
   // -------------------------------------------------------------------------
   aes_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_gnt_idx),
      .o_any (w_gnt_any)
   );

   // Grant is one-hot, so an AND-OR style mux with constant slices suffices.
   always_comb begin
      w_sel_data = '0;
      w_sel_key  = '0;
      for (int p = 0; p < NUM_REQ; p++) begin
         if (w_gnt[p]) begin
            w_sel_data = req_data[AES_BLOCK_W*p +: AES_BLOCK_W];
            w_sel_key  = req_key [AES_BLOCK_W*p +: AES_BLOCK_W];
         end
      end
   end

   // In IDLE the ready for the winner is raised whenever any valid is up, so
   // a grant is always a completed handshake.
   assign w_accept    = (r_state == IDLE) && w_gnt_any;
   assign w_core_done = (r_state == RUN)  && core_ready;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_gnt_any) w_state_nxt = LOAD;
         LOAD:    w_state_nxt = RUN;
         RUN:     if (core_ready || w_timeout) w_state_nxt = RESP;
         RESP:    if (rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // FSM: outputs
   // -------------------------------------------------------------------------
   // req_ready is masked while reset is high so no requester sees an accept
   // during reset even though the state already reads IDLE.
   always_comb begin
      req_ready    = '0;
      rsp_valid    = 1'b0;
      core_reset_n = 1'b0;
      case (r_state)
         IDLE:    if (!reset) req_ready = w_gnt;
         RUN:     core_reset_n = 1'b1;
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // Request latch: core inputs, response ID and round-robin pointer
   // -------------------------------------------------------------------------
   // The pointer resets to NUM_REQ-1 so that requester 0 is searched first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr      <= ID_W'(NUM_REQ-1);
         r_rsp_id   <= '0;
         r_core_in  <= '0;
         r_core_key <= '0;
      end else if (w_accept) begin
         r_ptr      <= w_gnt_idx;
         r_rsp_id   <= w_gnt_idx;
         r_core_in  <= w_sel_data;
         r_core_key <= w_sel_key;
      end
   end

   // -------------------------------------------------------------------------
   // Response data capture. core_ready beats the watchdog in the same cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_data <= '0;
      end else if (w_core_done) begin
         r_rsp_data <= core_out;
      end else if (w_timeout) begin
         r_rsp_data <= '0;
      end
   end

`ifdef AES_ARB_TIMEOUT_EN
   // -------------------------------------------------------------------------
   // RUN watchdog. Cleared while in LOAD (the only way into RUN), so in RUN
   // cycle k the counter reads k-1 and the limit fires on RUN cycle
   // TIMEOUT_CYCLES.
   // -------------------------------------------------------------------------
   localparam int TO_W = cnt_width(TIMEOUT_CYCLES);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_rsp_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt <= '0;
      end else if (r_state == LOAD) begin
         r_to_cnt <= '0;
      end else if (r_state == RUN) begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == RUN) && !core_ready &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYCLES-1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_err <= 1'b0;
      end else if (w_core_done) begin
         r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
         r_rsp_err <= 1'b1;
      end
   end

   assign rsp_err = r_rsp_err;
`else
   assign w_timeout = 1'b0;
   assign rsp_err   = 1'b0;
`endif

   assign rsp_data = r_rsp_data;
   assign rsp_id   = r_rsp_id;
   assign core_in  = r_core_in;
   assign core_key = r_core_key;

endmodule
